// File: rtl/iterative_shift_unit.sv
// Multi-cycle shift engine: one 1-bit shift per clock under control of a
// small FSM and a down-counter. Supports SLL/SRL/SRA; op=11 passes the
// operand through unchanged. Handshake is start/busy/done with a flush abort.
module iterative_shift_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               flush,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRes = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // State, datapath and result registers; async reset discards any operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= OpSll;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Next-state logic and the single-bit shift datapath.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = operand;
          cnt_d = shamt;
          op_d  = op;
          if ((shamt == '0) || (op == OpRes)) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        unique case (op_q)
          OpSll:   acc_d = {acc_q[WIDTH-2:0], 1'b0};
          OpSrl:   acc_d = {1'b0, acc_q[WIDTH-1:1]};
          OpSra:   acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
          default: acc_d = acc_q;
        endcase
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush overrides everything, including a start in IDLE.
    if (flush) begin
      state_d = StIdle;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
    end

    // Result is captured only on entry to DONE so it is valid alongside done.
    if (state_d == StDone) begin
      result_d = acc_d;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    result = result_q;
  end

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit with a behavioural shift model.
module tb_iterative_shift_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;

  iterative_shift_unit #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic shifts.
  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [4:0] s);
    case (o)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] o, input logic [4:0] s);
    if (s == 5'd0 || o == 2'b11) return 1;
    return int'(s) + 1;
  endfunction

  // Issues one request from an idle DUT; returns after the done cycle (or timeout).
  // Caller is #1 after a rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                       input bit scramble, output logic [31:0] res, output int lat,
                       output logic busy1);
    op = o; operand = a; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
    end
    busy1 = busy;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
  endtask

  task automatic test_sll_basic();
    logic [31:0] res; int lat; logic b1;
    issue(2'b00, 32'h1, 5'd1, 1'b0, res, lat, b1);
    checks++;
    if (b1 !== 1'b1) begin
      failures++; $display("FAIL sll_busy: got %b want 1", b1);
    end
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL sll_latency: got %0d want 2", lat);
    end
    checks++;
    if (res !== 32'h2) begin
      failures++; $display("FAIL sll_result: got %h want 00000002", res);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL sll_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_sra_sign();
    logic [31:0] res; int lat; logic b1;
    issue(2'b10, 32'h8000_0000, 5'd31, 1'b0, res, lat, b1);
    checks++;
    if (lat != 32 || res !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sra31: lat=%0d res=%h want 32 ffffffff", lat, res);
    end
    @(posedge clk); #1;
    issue(2'b01, 32'h8000_0000, 5'd31, 1'b0, res, lat, b1);
    checks++;
    if (lat != 32 || res !== 32'h1) begin
      failures++; $display("FAIL srl31: lat=%0d res=%h want 32 00000001", lat, res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_reserved();
    logic [31:0] res; int lat; logic b1;
    issue(2'b00, 32'hDEAD_BEEF, 5'd0, 1'b0, res, lat, b1);
    checks++;
    if (lat != 1 || res !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL zero_shamt: lat=%0d res=%h want 1 deadbeef", lat, res);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL zero_busy_len: busy=%b want 0", busy);
    end
    issue(2'b11, 32'hDEAD_BEEF, 5'd7, 1'b0, res, lat, b1);
    checks++;
    if (lat != 1 || res !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL reserved_op: lat=%0d res=%h want 1 deadbeef", lat, res);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reserved_busy_len: busy=%b want 0", busy);
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    op = 2'b00; operand = 32'h80; shamt = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    // Keep requesting with a different operand while the unit is working.
    operand = 32'h0000_FFFF; shamt = 5'd4;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || result !== 32'h100) begin
      failures++; $display("FAIL busy_first: done=%b res=%h want 1 00000100", done, result);
    end
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || result !== 32'h100) begin
      failures++; $display("FAIL busy_ignored: extra_dones=%0d res=%h want 0 00000100", dones, result);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; logic b1; logic [31:0] prior; int dones;
    issue(2'b00, 32'h0000_0005, 5'd3, 1'b0, prior, lat, b1);
    @(posedge clk); #1;
    op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 5'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h28) begin
      failures++;
      $display("FAIL flush_abort: busy=%b done=%b res=%h want 0 0 00000028", busy, done, result);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL flush_no_done: dones=%0d want 0", dones);
    end
    // Flush together with start in IDLE drops the start.
    op = 2'b00; operand = 32'h1; shamt = 5'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_drops_start: busy=%b want 0", busy);
    end
    issue(2'b01, 32'hF000_0000, 5'd4, 1'b0, res, lat, b1);
    checks++;
    if (lat != 5 || res !== 32'h0F00_0000) begin
      failures++; $display("FAIL flush_recover: lat=%0d res=%h want 5 0f000000", lat, res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [31:0] res; int lat; logic b1;
    op = 2'b00; operand = 32'h1234_5678; shamt = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b res=%h want 0 0 00000000", busy, done, result);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 32'h3, 5'd2, 1'b0, res, lat, b1);
    checks++;
    if (lat != 3 || res !== 32'hC) begin
      failures++; $display("FAIL reset_recover: lat=%0d res=%h want 3 0000000c", lat, res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] res; int lat; logic b1;
    logic [1:0] o; logic [31:0] a; logic [4:0] s;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      a = $urandom;
      if (i % 4 == 0) a[31] = 1'b1;
      s = 5'($urandom);
      issue(o, a, s, 1'b1, res, lat, b1);
      checks++;
      if (res !== model_result(o, a, s) || lat != model_latency(o, s) || b1 !== 1'b1) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h s=%0d: res=%h lat=%0d busy=%b want %h %0d 1",
                 i, o, a, s, res, lat, b1, model_result(o, a, s), model_latency(o, s));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; operand = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_sll_basic();
    test_sra_sign();
    test_zero_reserved();
    test_start_while_busy();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
